// File: rtl/ippcrc_crc32_stream.sv
// Frame-aware, DW-wide CRC-32 engine (poly 0x04C11DB7) with valid/ready input and result channels.
// Generates a reflected/xored FCS or checks a message+FCS against the fixed residue.
module ippcrc_crc32_stream #(
    parameter int          DW      = 32,
    parameter int          NBW     = (DW / 8 > 1) ? $clog2(DW / 8) : 1,
    parameter logic [31:0] INIT    = 32'hFFFF_FFFF,
    parameter logic [31:0] XOROUT  = 32'hFFFF_FFFF,
    parameter bit          REFOUT  = 1'b1,
    parameter logic [31:0] RESIDUE = 32'hC704_DD7B
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_vld,
    output logic           in_rdy,
    input  logic           in_sop,
    input  logic           in_eop,
    input  logic [NBW-1:0] in_nbm1,
    input  logic [DW-1:0]  in_data,
    input  logic           in_mode,
    output logic           res_vld,
    input  logic           res_rdy,
    output logic [31:0]    res_crc,
    output logic           res_ok,
    output logic [15:0]    res_len,
    output logic           proto_err
);

    localparam int             NB       = DW / 8;
    localparam logic [31:0]    POLY     = 32'h04C1_1DB7;
    localparam logic [NBW-1:0] NBM1_MAX = NBW'(NB - 1);
    localparam logic [NBW:0]   FULL_LEN = (NBW + 1)'(NB);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Register is MSB-first; the byte enters reflected so its bit 0 is processed first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {rev8(b), 24'h0};
        for (int i = 0; i < 8; i++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mode_q, mode_d;
    logic        res_vld_q, res_vld_d;
    logic [31:0] res_crc_q, res_crc_d;
    logic        res_ok_q, res_ok_d;
    logic [15:0] res_len_q, res_len_d;
    logic        proto_err_q, proto_err_d;

    logic           accept;
    logic [NBW-1:0] nbm1_clamp;
    logic [NB-1:0]  lane_en;
    logic [7:0]     lane_byte [NB];
    logic [NBW:0]   beat_len;
    logic [31:0]    crc_start;
    logic [31:0]    crc_new;
    logic [16:0]    cnt_sum;
    logic [15:0]    cnt_new;

    assign in_rdy = ~res_vld_q | res_rdy;
    assign accept = in_vld & in_rdy;

    assign nbm1_clamp = (in_nbm1 > NBM1_MAX) ? NBM1_MAX : in_nbm1;
    assign beat_len   = in_eop ? ((NBW + 1)'(nbm1_clamp) + 1'b1) : FULL_LEN;

    // Valid lanes are always a contiguous run starting at lane 0.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign lane_en[gi]   = ~in_eop | (NBW'(gi) <= nbm1_clamp);
        assign lane_byte[gi] = in_data[8*gi +: 8];
    end

    assign crc_start = in_sop ? INIT : crc_q;

    always_comb begin
        crc_new = crc_start;
        for (int i = 0; i < NB; i++) begin
            if (lane_en[i]) crc_new = crc_byte(crc_new, lane_byte[i]);
        end
    end

    assign cnt_sum = {1'b0, (in_sop ? 16'h0 : cnt_q)} + 17'(beat_len);
    assign cnt_new = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            crc_q       <= INIT;
            cnt_q       <= 16'h0;
            mode_q      <= 1'b0;
            res_vld_q   <= 1'b0;
            res_crc_q   <= 32'h0;
            res_ok_q    <= 1'b0;
            res_len_q   <= 16'h0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            res_vld_q   <= res_vld_d;
            res_crc_q   <= res_crc_d;
            res_ok_q    <= res_ok_d;
            res_len_q   <= res_len_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && in_sop && !in_eop) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (accept && in_eop) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and result control
    always_comb begin
        logic take_beat;
        logic frame_mode;

        take_beat  = accept && (in_sop || (state_q == ST_ACTIVE));
        frame_mode = in_sop ? in_mode : mode_q;

        crc_d       = crc_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        res_vld_d   = res_vld_q & ~res_rdy;
        res_crc_d   = res_crc_q;
        res_ok_d    = res_ok_q;
        res_len_d   = res_len_q;
        proto_err_d = accept && (((state_q == ST_IDLE) && !in_sop) ||
                                 ((state_q == ST_ACTIVE) && in_sop));

        if (take_beat) begin
            crc_d  = crc_new;
            cnt_d  = cnt_new;
            mode_d = frame_mode;
            if (in_eop) begin
                res_vld_d = 1'b1;
                res_len_d = cnt_new;
                if (frame_mode) begin
                    res_crc_d = crc_new;
                    res_ok_d  = (crc_new == RESIDUE);
                end else begin
                    res_crc_d = (REFOUT ? rev32(crc_new) : crc_new) ^ XOROUT;
                    res_ok_d  = 1'b1;
                end
            end
        end
    end

    assign res_vld   = res_vld_q;
    assign res_crc   = res_crc_q;
    assign res_ok    = res_ok_q;
    assign res_len   = res_len_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_ippcrc_crc32_stream.sv
// Directed bench for ippcrc_crc32_stream (DW=32): known CRC-32 vectors, handshakes, framing errors, reset.
module tb_ippcrc_crc32_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vld;
    logic        in_rdy;
    logic        in_sop;
    logic        in_eop;
    logic [1:0]  in_nbm1;
    logic [31:0] in_data;
    logic        in_mode;
    logic        res_vld;
    logic        res_rdy;
    logic [31:0] res_crc;
    logic        res_ok;
    logic [15:0] res_len;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    ippcrc_crc32_stream #(.DW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_nbm1   (in_nbm1),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .res_vld   (res_vld),
        .res_rdy   (res_rdy),
        .res_crc   (res_crc),
        .res_ok    (res_ok),
        .res_len   (res_len),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    // Present one beat, wait (bounded) for in_rdy, let it be accepted, return 1 time unit after the edge.
    task automatic drive(input logic sop, input logic eop, input logic [1:0] nbm1,
                         input logic [31:0] data, input logic mode);
        int n;
        in_vld  = 1'b1;
        in_sop  = sop;
        in_eop  = eop;
        in_nbm1 = nbm1;
        in_data = data;
        in_mode = mode;
        n = 0;
        while (!in_rdy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!in_rdy) begin
            errors++;
            $display("FAIL drive_timeout in_rdy=%0b required 1", in_rdy);
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        in_sop = 1'b0;
        in_eop = 1'b0;
    endtask

    task automatic accept_result();
        res_rdy = 1'b1;
        @(posedge clk);
        #1;
        res_rdy = 1'b0;
    endtask

    task automatic send_123456789(input logic mode);
        drive(1'b1, 1'b0, 2'd3, 32'h34333231, mode);
        drive(1'b0, 1'b0, 2'd3, 32'h38373635, ~mode);
        drive(1'b0, 1'b1, 2'd0, 32'h00000039, ~mode);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({res_vld, res_crc, res_ok, res_len, proto_err} !== 51'h0) begin
            errors++;
            $display("FAIL reset_outputs vld=%0b crc=%h ok=%0b len=%0d perr=%0b required all 0",
                     res_vld, res_crc, res_ok, res_len, proto_err);
        end
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_rdy got %0b required 1", in_rdy);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_generate();
        send_123456789(1'b0);
        $display("gen 123456789: vld=%0b crc=%h ok=%0b len=%0d", res_vld, res_crc, res_ok, res_len);
        checks++;
        if (res_vld !== 1'b1) begin
            errors++;
            $display("FAIL gen_vld got %0b required 1", res_vld);
        end
        checks++;
        if (res_crc !== 32'hCBF43926) begin
            errors++;
            $display("FAIL gen_crc got %h required cbf43926", res_crc);
        end
        checks++;
        if (res_len !== 16'd9 || res_ok !== 1'b1) begin
            errors++;
            $display("FAIL gen_len_ok got len=%0d ok=%0b required len=9 ok=1", res_len, res_ok);
        end
        accept_result();
        checks++;
        if (res_vld !== 1'b0) begin
            errors++;
            $display("FAIL gen_vld_clear got %0b required 0", res_vld);
        end
    endtask

    task automatic test_check();
        drive(1'b1, 1'b0, 2'd3, 32'h34333231, 1'b1);
        drive(1'b0, 1'b0, 2'd3, 32'h38373635, 1'b0);
        drive(1'b0, 1'b0, 2'd3, 32'hF4392639, 1'b0);
        drive(1'b0, 1'b1, 2'd0, 32'h000000CB, 1'b0);
        $display("chk good: vld=%0b crc=%h ok=%0b len=%0d", res_vld, res_crc, res_ok, res_len);
        checks++;
        if (res_vld !== 1'b1 || res_crc !== 32'hC704DD7B) begin
            errors++;
            $display("FAIL chk_crc got vld=%0b crc=%h required vld=1 crc=c704dd7b", res_vld, res_crc);
        end
        checks++;
        if (res_ok !== 1'b1 || res_len !== 16'd13) begin
            errors++;
            $display("FAIL chk_ok_len got ok=%0b len=%0d required ok=1 len=13", res_ok, res_len);
        end
        accept_result();
        drive(1'b1, 1'b0, 2'd3, 32'h34333230, 1'b1);
        drive(1'b0, 1'b0, 2'd3, 32'h38373635, 1'b0);
        drive(1'b0, 1'b0, 2'd3, 32'hF4392639, 1'b0);
        drive(1'b0, 1'b1, 2'd0, 32'h000000CB, 1'b0);
        $display("chk flipped: vld=%0b crc=%h ok=%0b len=%0d", res_vld, res_crc, res_ok, res_len);
        checks++;
        if (res_vld !== 1'b1 || res_ok !== 1'b0 || res_len !== 16'd13) begin
            errors++;
            $display("FAIL chk_bad got vld=%0b ok=%0b len=%0d required vld=1 ok=0 len=13",
                     res_vld, res_ok, res_len);
        end
        accept_result();
    endtask

    task automatic test_single_beat();
        drive(1'b1, 1'b1, 2'd3, 32'h34333231, 1'b0);
        $display("gen 1234: vld=%0b crc=%h ok=%0b len=%0d", res_vld, res_crc, res_ok, res_len);
        checks++;
        if (res_vld !== 1'b1 || res_crc !== 32'h9BE3E0A3 || res_len !== 16'd4) begin
            errors++;
            $display("FAIL single_beat got vld=%0b crc=%h len=%0d required vld=1 crc=9be3e0a3 len=4",
                     res_vld, res_crc, res_len);
        end
        accept_result();
    endtask

    task automatic test_back_to_back();
        res_rdy = 1'b1;
        in_vld  = 1'b1;
        in_sop  = 1'b1;
        in_eop  = 1'b1;
        in_nbm1 = 2'd3;
        in_data = 32'h34333231;
        in_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            $display("b2b %0d: vld=%0b rdy=%0b crc=%h len=%0d", i, res_vld, in_rdy, res_crc, res_len);
            checks++;
            if (res_vld !== 1'b1 || in_rdy !== 1'b1 || res_crc !== 32'h9BE3E0A3) begin
                errors++;
                $display("FAIL b2b_%0d got vld=%0b rdy=%0b crc=%h required vld=1 rdy=1 crc=9be3e0a3",
                         i, res_vld, in_rdy, res_crc);
            end
        end
        in_vld = 1'b0;
        in_sop = 1'b0;
        in_eop = 1'b0;
        @(posedge clk);
        #1;
        res_rdy = 1'b0;
        checks++;
        if (res_vld !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got vld=%0b required 0", res_vld);
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 1'b1, 2'd3, 32'h34333231, 1'b0);
        checks++;
        if (res_vld !== 1'b1 || in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL bp_block got vld=%0b rdy=%0b required vld=1 rdy=0", res_vld, in_rdy);
        end
        // A sop-less beat would raise proto_err if it slipped through while blocked.
        in_vld  = 1'b1;
        in_sop  = 1'b0;
        in_eop  = 1'b1;
        in_data = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (res_vld !== 1'b1 || res_crc !== 32'h9BE3E0A3 || res_len !== 16'd4 || proto_err !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d got vld=%0b crc=%h len=%0d perr=%0b required 1 9be3e0a3 4 0",
                         i, res_vld, res_crc, res_len, proto_err);
            end
        end
        in_vld  = 1'b0;
        in_eop  = 1'b0;
        res_rdy = 1'b1;
        #1;
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_rdy got %0b required 1", in_rdy);
        end
        @(posedge clk);
        #1;
        res_rdy = 1'b0;
        $display("bp released: vld=%0b", res_vld);
        checks++;
        if (res_vld !== 1'b0) begin
            errors++;
            $display("FAIL bp_release_vld got %0b required 0", res_vld);
        end
    endtask

    task automatic test_proto();
        drive(1'b0, 1'b1, 2'd3, 32'h34333231, 1'b0);
        checks++;
        if (proto_err !== 1'b1 || res_vld !== 1'b0) begin
            errors++;
            $display("FAIL proto_nosop got perr=%0b vld=%0b required perr=1 vld=0", proto_err, res_vld);
        end
        @(posedge clk);
        #1;
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL proto_pulse got %0b required 0", proto_err);
        end
        drive(1'b1, 1'b0, 2'd3, 32'h11223344, 1'b0);
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL proto_first_sop got %0b required 0", proto_err);
        end
        drive(1'b1, 1'b0, 2'd3, 32'h34333231, 1'b0);
        checks++;
        if (proto_err !== 1'b1 || res_vld !== 1'b0) begin
            errors++;
            $display("FAIL proto_restart got perr=%0b vld=%0b required perr=1 vld=0", proto_err, res_vld);
        end
        drive(1'b0, 1'b0, 2'd3, 32'h38373635, 1'b0);
        drive(1'b0, 1'b1, 2'd0, 32'h00000039, 1'b0);
        $display("restarted frame: vld=%0b crc=%h len=%0d", res_vld, res_crc, res_len);
        checks++;
        if (res_vld !== 1'b1 || res_crc !== 32'hCBF43926 || res_len !== 16'd9) begin
            errors++;
            $display("FAIL proto_result got vld=%0b crc=%h len=%0d required vld=1 crc=cbf43926 len=9",
                     res_vld, res_crc, res_len);
        end
        accept_result();
        @(posedge clk);
        #1;
        checks++;
        if (res_vld !== 1'b0) begin
            errors++;
            $display("FAIL proto_single_result got vld=%0b required 0", res_vld);
        end
    endtask

    task automatic test_reset_midframe();
        drive(1'b1, 1'b0, 2'd3, 32'h34333231, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Partial frame must be gone: a continuation beat is now a framing error.
        drive(1'b0, 1'b0, 2'd3, 32'h38373635, 1'b0);
        checks++;
        if (proto_err !== 1'b1 || res_vld !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got perr=%0b vld=%0b required perr=1 vld=0", proto_err, res_vld);
        end
        drive(1'b1, 1'b1, 2'd3, 32'h34333231, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if ({res_vld, res_crc, res_ok, res_len, proto_err} !== 51'h0 || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pending got vld=%0b crc=%h ok=%0b len=%0d rdy=%0b required zeros rdy=1",
                     res_vld, res_crc, res_ok, res_len, in_rdy);
        end
        send_123456789(1'b0);
        $display("post-reset 123456789: vld=%0b crc=%h len=%0d", res_vld, res_crc, res_len);
        checks++;
        if (res_vld !== 1'b1 || res_crc !== 32'hCBF43926 || res_len !== 16'd9) begin
            errors++;
            $display("FAIL rst_after got vld=%0b crc=%h len=%0d required vld=1 crc=cbf43926 len=9",
                     res_vld, res_crc, res_len);
        end
        accept_result();
    endtask

    task automatic test_len_saturation();
        // 16401 full beats = 65604 bytes, beyond the 16-bit counter range.
        in_vld  = 1'b1;
        in_nbm1 = 2'd3;
        in_data = 32'hA5A5A5A5;
        in_mode = 1'b0;
        for (int i = 0; i < 16401; i++) begin
            in_sop = (i == 0);
            in_eop = (i == 16400);
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0;
        in_sop = 1'b0;
        in_eop = 1'b0;
        $display("long frame: vld=%0b len=%h", res_vld, res_len);
        checks++;
        if (res_vld !== 1'b1 || res_len !== 16'hFFFF) begin
            errors++;
            $display("FAIL len_sat got vld=%0b len=%h required vld=1 len=ffff", res_vld, res_len);
        end
        accept_result();
    endtask

    initial begin
        in_vld  = 1'b0;
        in_sop  = 1'b0;
        in_eop  = 1'b0;
        in_nbm1 = 2'd0;
        in_data = 32'h0;
        in_mode = 1'b0;
        res_rdy = 1'b0;
        rst_n   = 1'b0;
        test_reset();
        test_generate();
        test_check();
        test_single_beat();
        test_back_to_back();
        test_backpressure();
        test_proto();
        test_reset_midframe();
        test_len_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ippcrc_crc32_stream.md
Name: ippcrc_crc32_stream

Overview:
Parametrised, pipelined, frame-aware CRC-32 engine (polynomial 0x04C11DB7) for the ippcrc package. It generalises the fixed-width combinational CRC-32 step to a configurable datapath width with byte-granular last beat. It adds frame control (sop/eop), valid/ready handshakes, init/xorout/reflect options, a generate/check mode and a frame byte counter. It sits between packet framers and MAC/FCS insert/strip logic.

Parameters:
DW, 32, datapath width in bits; multiple of 8, range 8..128.
NBW, max(1,clog2(DW/8)), width of in_nbm1.
INIT, 32'hFFFFFFFF, CRC register value loaded at sop.
XOROUT, 32'hFFFFFFFF, XOR applied to generated CRC.
REFOUT, 1, 1 = bit-reverse the register before XOROUT in generate mode.
RESIDUE, 32'hC704DD7B, expected raw register value after message+FCS in check mode.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
in_vld  in  1  input beat valid.
in_rdy  out  1  input ready; beat accepted when in_vld & in_rdy.
in_sop  in  1  first beat of frame.
in_eop  in  1  last beat of frame.
in_nbm1  in  NBW  valid bytes minus 1 on eop beat; ignored (all lanes valid) otherwise.
in_data  in  DW  data; lane k = in_data[8k+7:8k]; lane 0 first, bit 0 of each lane first.
in_mode  in  1  sampled on sop beat: 0 = generate, 1 = check.
res_vld  out  1  result valid.
res_rdy  in  1  result accepted when res_vld & res_rdy.
res_crc  out  32  generate: final CRC; check: raw register.
res_ok  out  1  check mode: raw register == RESIDUE; generate mode: 1.
res_len  out  16  frame byte count, saturating at 16'hFFFF.
proto_err  out  1  one-cycle pulse on framing violation.

Behaviour:
- Reset (rst_n low at clk edge): state IDLE, crc reg = INIT, count = 0, res_vld=0, res_crc=0, res_ok=0, res_len=0, proto_err=0. in_rdy=1 after reset. Reset takes effect in any state and discards any partial frame or pending result.
- Byte update: per byte b, the reg is XORed with reverse8(b) in bits [31:24], then shifted left 8 times with poly 0x04C11DB7. This is MSB-of-register-first, data LSB-first. Lanes are chained 0..L-1, where L = DW/8 on non-eop beats and in_nbm1+1 on eop beats. Lanes above L are ignored. The chain is a single-cycle combinational XOR network.
- in_rdy = ~res_vld | res_rdy. This is combinational, and is the only backpressure source.
- FSM IDLE:
  - Accepted beat with sop=1: next reg = update(INIT, beat), count = L, mode latched. Go to ACTIVE, unless eop=1 in the same beat (single-beat frame, stay IDLE, produce result).
  - Accepted beat with sop=0: discarded, proto_err=1 for one cycle.
- FSM ACTIVE:
  - Accepted beat with sop=0: reg = update(reg, beat), count += L, saturating.
  - eop=1: produce result, go to IDLE.
  - sop=1: restart from INIT using that beat, no result for the aborted frame, proto_err=1.
- Result: eop beat accepted at edge N gives res_vld=1 from N+1, holding all res_* stable until res_rdy.
  - Generate: res_crc = (REFOUT ? reverse32(reg) : reg) ^ XOROUT.
  - Check: res_crc = raw reg, res_ok = (reg == RESIDUE).
  - A new result may load on the same edge the old one is accepted, giving back-to-back results every cycle.
- in_mode is ignored on non-sop beats. in_nbm1 values above DW/8-1 are treated as DW/8-1.
- Idle data lines (in_vld=0) have no effect on state.

Test Plan:
- DW=32, generate, "123456789": beats 0x34333231(sop), 0x38373635, 0x00000039(eop, nbm1=0) -> res_vld 1 cycle after eop, res_crc=0xCBF43926, res_len=9, res_ok=1.
- Same with DW=32, check mode, beats 0x34333231(sop), 0x38373635, 0xF4392639, 0x000000CB(eop, nbm1=0) -> res_crc=0xC704DD7B, res_ok=1, res_len=13. Flip one data bit -> res_ok=0.
- Single-beat frame sop=eop=1, data 0x34333231, nbm1=3, generate -> res_crc=0x9BE3E0A3, res_len=4. Repeat same frame on consecutive cycles with res_rdy=1 -> res_vld continuously high, in_rdy=1 throughout.
- Hold res_rdy=0 with a pending result -> in_rdy=0, res_* stable. Release -> in_rdy=1 the same cycle.
- Beat without sop in IDLE -> proto_err pulse, no result. sop mid-frame -> proto_err pulse, only the restarted frame yields a result.
- rst_n low mid-frame and with a pending result -> all outputs zero next edge. The following "123456789" frame -> 0xCBF43926.
